// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between the MEM-stage store port and the data memory
// write port. The pipeline hands off a store in one cycle. The buffer drains
// stores to memory in program order, and each write completes when memory
// acknowledges it. Loads to a buffered word receive the youngest buffered
// data, so they never read stale memory.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low (0 = in reset)
//   memwrite     MEM-stage store request
//   memread      MEM-stage load request
//   dataadr      store/load byte address
//   writedata    store data
//   stall        store rejected this cycle (buffer full)
//   rd_hit       load word matches an occupied entry
//   rd_fwd_data  youngest matching entry data when rd_hit, else 0
//   mem_we       head entry valid and offered to memory
//   mem_adr      head entry address (0 when empty)
//   mem_wd       head entry data (0 when empty)
//   mem_ack      memory accepts the offered write this cycle
//   count        occupied entries
//   empty        count == 0
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic                     memread,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     rd_hit,
    output logic [DW-1:0]            rd_fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wd,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] adr_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;

    logic full;
    logic is_empty;
    logic push;
    logic pop;

    assign full     = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // The full check uses the current count. A pop in the same cycle does
    // not free a slot for this push, so the stall path stays short.
    assign push = memwrite & ~full;
    assign pop  = mem_ack & ~is_empty;

    assign stall = memwrite & full;
    assign count = count_q;
    assign empty = is_empty;

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so that
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    // NOTE: the entry arrays have no reset. Occupancy comes only from
    // head/count, so stale contents are never observed, and the arrays can
    // map to plain RAM/flops with no reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[tail]  <= dataadr;
            data_mem[tail] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Drain port: the head entry is offered whenever the buffer is occupied
    // ------------------------------------------------------------------
    assign mem_we  = ~is_empty;
    assign mem_adr = is_empty ? '0 : adr_mem[head];
    assign mem_wd  = is_empty ? '0 : data_mem[head];

    // ------------------------------------------------------------------
    // Load forwarding
    // ------------------------------------------------------------------
    // Entries are scanned oldest-to-youngest from head. A later match
    // overwrites an earlier one, so the youngest matching store wins.
    // The head entry stays visible in its pop cycle because count_q has
    // not yet decremented.
    logic          scan_hit;
    logic [DW-1:0] scan_data;
    logic [PW-1:0] scan_idx;

    // NOTE: combinational blocks use blocking (=) assignments. Every output
    // gets a default first, so no latch is inferred on any path.
    always_comb begin
        scan_hit  = 1'b0;
        scan_data = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if ((CW'(k) < count_q) &&
                (adr_mem[scan_idx][AW-1:2] == dataadr[AW-1:2])) begin
                scan_hit  = 1'b1;
                scan_data = data_mem[scan_idx];
            end
        end
    end

    // A simultaneous store owns dataadr this cycle, so the load is ignored.
    // The store being pushed is never forwarded because it is not yet
    // occupied.
    assign rd_hit      = memread & ~memwrite & scan_hit;
    assign rd_fwd_data = rd_hit ? scan_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Directed stimulus for store_buffer. Each accepted store pushes its
// expected memory write {adr, wd} into a queue. A monitor samples on the
// falling edge. When it sees mem_we & mem_ack, it pops the queue and
// compares. Status outputs are checked inline against hand-computed values.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] wd;
    } wr_t;

    logic                   clk;
    logic                   reset;
    logic                   memwrite;
    logic                   memread;
    logic [AW-1:0]          dataadr;
    logic [DW-1:0]          writedata;
    logic                   stall;
    logic                   rd_hit;
    logic [DW-1:0]          rd_fwd_data;
    logic                   mem_we;
    logic [AW-1:0]          mem_adr;
    logic [DW-1:0]          mem_wd;
    logic                   mem_ack;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .memread     (memread),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .stall       (stall),
        .rd_hit      (rd_hit),
        .rd_fwd_data (rd_fwd_data),
        .mem_we      (mem_we),
        .mem_adr     (mem_adr),
        .mem_wd      (mem_wd),
        .mem_ack     (mem_ack),
        .count       (count),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a handshake seen at the falling edge completes on
    // the following rising edge.
    always @(negedge clk) begin
        if (reset && mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("drain_adr", mem_adr, e.adr);
                check("drain_wd",  mem_wd,  e.wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store that must be accepted. The expected write is queued.
    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        exp_q.push_back('{adr: a, wd: d});
        tick();
        memwrite = 1'b0;
    endtask

    task automatic drain(input int n);
        mem_ack = 1'b1;
        repeat (n) tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset with a store presented: nothing is enqueued.
        reset     = 1'b0;
        memwrite  = 1'b1;
        memread   = 1'b0;
        dataadr   = 32'd80;
        writedata = 32'd7;
        mem_ack   = 1'b0;
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_count",  32'(count),  32'd0);
        check("rst_empty",  32'(empty),  32'd1);
        check("rst_stall",  32'(stall),  32'd0);
        #11 memwrite = 1'b0;
        #1  reset    = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);
        tick();

        // 2. A single store is held stable until it is acknowledged.
        store(32'd80, 32'd7);
        repeat (3) begin
            @(negedge clk);
            check("t2_count",   32'(count),  32'd1);
            check("t2_mem_we",  32'(mem_we), 32'd1);
            check("t2_mem_adr", mem_adr,     32'd80);
            check("t2_mem_wd",  mem_wd,      32'd7);
            tick();
        end
        drain(1);
        @(negedge clk);
        check("t2_count_after", 32'(count),  32'd0);
        check("t2_we_after",    32'(mem_we), 32'd0);
        tick();

        // 3. Fill the buffer, stall a fifth store, and free a slot with a pop.
        store(32'd80, 32'h10);
        store(32'd84, 32'h11);
        store(32'd88, 32'h12);
        store(32'd92, 32'h13);
        memwrite  = 1'b1;
        dataadr   = 32'd96;
        writedata = 32'h14;
        @(negedge clk);
        check("t3_full_count", 32'(count), 32'd4);
        check("t3_stall",      32'(stall), 32'd1);
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        check("t3_count_held",  32'(count), 32'd4);
        check("t3_stall_w_pop", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        check("t3_count_popped", 32'(count), 32'd3);
        check("t3_stall_clear",  32'(stall), 32'd0);
        exp_q.push_back('{adr: 32'd96, wd: 32'h14});
        tick();
        memwrite = 1'b0;
        @(negedge clk);
        check("t3_count_refill", 32'(count), 32'd4);
        tick();
        drain(4);
        @(negedge clk);
        check("t3_empty", 32'(empty), 32'd1);
        tick();

        // 4. Forwarding: the youngest entry wins, and matching is at word granularity.
        store(32'd84, 32'd1);
        store(32'd84, 32'd241);
        memread = 1'b1;
        dataadr = 32'd84;
        @(negedge clk);
        check("t4_hit84",  32'(rd_hit),  32'd1);
        check("t4_fwd84",  rd_fwd_data,  32'd241);
        dataadr = 32'd86;
        #1;
        check("t4_hit86",  32'(rd_hit),  32'd1);
        check("t4_fwd86",  rd_fwd_data,  32'd241);
        dataadr = 32'd88;
        #1;
        check("t4_hit88",  32'(rd_hit),  32'd0);
        check("t4_fwd88",  rd_fwd_data,  32'd0);
        memwrite = 1'b1;
        dataadr  = 32'd84;
        #1;
        check("t4_rw_hit", 32'(rd_hit),  32'd0);
        check("t4_rw_fwd", rd_fwd_data,  32'd0);
        memwrite = 1'b0;
        memread  = 1'b0;
        tick();
        mem_ack = 1'b1;
        memread = 1'b1;
        dataadr = 32'd84;
        @(negedge clk);
        check("t4_pop_fwd2", rd_fwd_data, 32'd241);
        tick();
        @(negedge clk);
        check("t4_head_pop_hit", 32'(rd_hit), 32'd1);
        check("t4_head_pop_fwd", rd_fwd_data, 32'd241);
        tick();
        mem_ack = 1'b0;
        memread = 1'b0;
        @(negedge clk);
        check("t4_empty", 32'(empty), 32'd1);
        tick();

        // 5. Simultaneous push and pop at count 2 across pointer wrap.
        store(32'd100, 32'hA0);
        store(32'd104, 32'hA1);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            memwrite  = 1'b1;
            dataadr   = 32'd108 + 32'(4 * i);
            writedata = 32'hB0 + 32'(i);
            mem_ack   = 1'b1;
            exp_q.push_back('{adr: dataadr, wd: writedata});
            @(negedge clk);
            check("t5_count", 32'(count), 32'd2);
            check("t5_stall", 32'(stall), 32'd0);
            tick();
        end
        memwrite = 1'b0;
        drain(2);
        @(negedge clk);
        check("t5_empty", 32'(empty), 32'd1);
        tick();

        // 6. Asynchronous reset in the middle of a drain.
        store(32'd200, 32'hC0);
        store(32'd204, 32'hC1);
        store(32'd208, 32'hC2);
        store(32'd212, 32'hC3);
        drain(1);
        @(negedge clk);
        check("t6_count_mid", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("t6_async_we",    32'(mem_we), 32'd0);
        check("t6_async_count", 32'(count),  32'd0);
        check("t6_async_adr",   mem_adr,     32'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        store(32'd84, 32'd241);
        drain(1);
        @(negedge clk);
        check("t6_empty", 32'(empty), 32'd1);

        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
